// File: rtl/approximate_error_recovery_if.sv
// Handshake bundle between the approximate-adder checker and its producer/consumer.
// The producer/consumer side uses master; the recovery block uses slave.
interface approximate_error_recovery_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 2)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   exact_sum;
   logic [WIDTH-1:0] approx_sum;
   logic [WIDTH-1:0] err_dist;
   logic             err_flag;
   logic [CNT_W-1:0] iter_cnt;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, exact_sum, approx_sum, err_dist, err_flag, iter_cnt
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, exact_sum, approx_sum, err_dist, err_flag, iter_cnt
   );
endinterface

// File: rtl/approximate_error_recovery.sv
// Recovers the exact sum A+B from the OR-approximation S'=A|B and the dropped
// carries E=A&B by iterative carry propagation; also reports the error distance.
module approximate_error_recovery #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                         clk,
   input  logic                         rst,
   approximate_error_recovery_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH:0]   s_reg;
   logic [WIDTH:0]   e_reg;
   logic [WIDTH:0]   s_xor;
   logic [WIDTH:0]   e_nxt;
   logic [WIDTH-1:0] and_ab;
   logic [WIDTH-1:0] or_ab;
   logic [WIDTH:0]   exact_reg;
   logic [WIDTH-1:0] approx_reg;
   logic [WIDTH-1:0] err_reg;
   logic             flag_reg;
   logic [CNT_W-1:0] iter_reg;

   assign and_ab = bus.a & bus.b;
   assign or_ab  = bus.a | bus.b;
   assign s_xor  = s_reg ^ e_reg;
   // S+E is invariant across a round; the carry out of the top bit is dropped
   // because the true sum always fits in WIDTH+1 bits.
   assign e_nxt  = (s_reg & e_reg) << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = (and_ab == '0) ? DONE : ITER;
         ITER: if (e_nxt == '0) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg      <= '0;
         e_reg      <= '0;
         exact_reg  <= '0;
         approx_reg <= '0;
         err_reg    <= '0;
         flag_reg   <= 1'b0;
         iter_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  s_reg      <= {1'b0, or_ab};
                  e_reg      <= {1'b0, and_ab};
                  approx_reg <= or_ab;
                  err_reg    <= and_ab;
                  flag_reg   <= |and_ab;
                  iter_reg   <= '0;
                  if (and_ab == '0) exact_reg <= {1'b0, or_ab};
               end
            end
            ITER: begin
               s_reg    <= s_xor;
               e_reg    <= e_nxt;
               iter_reg <= iter_reg + CNT_W'(1);
               if (e_nxt == '0) exact_reg <= s_xor;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.exact_sum  = exact_reg;
   assign bus.approx_sum = approx_reg;
   assign bus.err_dist   = err_reg;
   assign bus.err_flag   = flag_reg;
   assign bus.iter_cnt   = iter_reg;

endmodule

// File: tb/tb_approximate_error_recovery.sv
// Directed and randomized checks of approximate_error_recovery against a
// reference built from plain integer arithmetic.
module tb_approximate_error_recovery;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam int NRAND = 5000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   approximate_error_recovery_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   approximate_error_recovery #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rounds of carry propagation until no carry remains, on (WIDTH+1)-bit values
   function automatic int refIters(input int a, input int b);
      int s, e, c, n;
      s = a | b;
      e = a & b;
      n = 0;
      while (e != 0 && n < 64) begin
         c = s & e;
         s = s ^ e;
         e = (c << 1) & ((1 << (WIDTH + 1)) - 1);
         n++;
      end
      return n;
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int latency);
      @(negedge clk);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      latency = 1;
      #1;
      bus.in_valid = 1'b0;
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      while (bus.out_valid !== 1'b1 && latency < 2 * WIDTH + 6) begin
         @(posedge clk);
         latency++;
         #1;
      end
   endtask

   task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_sum, input int exp_iter);
      int lat;
      applyStimulus(a, b, lat);
      checkOutput({tag, "_out_valid"}, bus.out_valid, 1);
      checkOutput({tag, "_latency"}, lat, 1 + exp_iter);
      checkOutput({tag, "_exact_sum"}, bus.exact_sum, exp_sum);
      checkOutput({tag, "_approx_sum"}, bus.approx_sum, a | b);
      checkOutput({tag, "_err_dist"}, bus.err_dist, a & b);
      checkOutput({tag, "_err_flag"}, bus.err_flag, ((a & b) != 0) ? 1 : 0);
      checkOutput({tag, "_iter_cnt"}, bus.iter_cnt, exp_iter);
      checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
   endtask

   task automatic releaseOutput(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_rel_out_valid"}, bus.out_valid, 0);
      checkOutput({tag, "_rel_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int it;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;

      #2 rst = 1'b1;
      #1;
      checkOutput("reset_in_ready", bus.in_ready, 1);
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_exact_sum", bus.exact_sum, 0);
      checkOutput("reset_err_dist", bus.err_dist, 0);
      checkOutput("reset_iter_cnt", bus.iter_cnt, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      runOp("no_carry", 8'd5, 8'd10, 15, 0);
      releaseOutput("no_carry");
      runOp("small", 8'd3, 8'd1, 4, 3);
      releaseOutput("small");
      runOp("chain", 8'd255, 8'd1, 256, 9);
      releaseOutput("chain");
      runOp("max", 8'd255, 8'd255, 510, 2);
      releaseOutput("max");

      // Held result must not move while the consumer stalls, even with new offers
      runOp("bp", 8'd3, 8'd1, 4, 3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a        = WIDTH'($urandom);
         bus.b        = WIDTH'($urandom);
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", bus.out_valid, 1);
         checkOutput("bp_in_ready", bus.in_ready, 0);
         checkOutput("bp_exact_sum", bus.exact_sum, 4);
         checkOutput("bp_err_dist", bus.err_dist, 1);
         checkOutput("bp_iter_cnt", bus.iter_cnt, 3);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      releaseOutput("bp");
      checkOutput("idle_hold_exact_sum", bus.exact_sum, 4);
      checkOutput("idle_hold_approx_sum", bus.approx_sum, 3);
      checkOutput("idle_hold_err_dist", bus.err_dist, 1);

      @(negedge clk);
      bus.a        = 8'd255;
      bus.b        = 8'd1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pre_rst_in_ready", bus.in_ready, 0);
      checkOutput("pre_rst_out_valid", bus.out_valid, 0);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_in_ready", bus.in_ready, 1);
      checkOutput("mid_rst_out_valid", bus.out_valid, 0);
      checkOutput("mid_rst_exact_sum", bus.exact_sum, 0);
      checkOutput("mid_rst_approx_sum", bus.approx_sum, 0);
      checkOutput("mid_rst_err_dist", bus.err_dist, 0);
      checkOutput("mid_rst_err_flag", bus.err_flag, 0);
      checkOutput("mid_rst_iter_cnt", bus.iter_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      runOp("after_rst", 8'd7, 8'd9, 16, refIters(7, 9));
      releaseOutput("after_rst");

      for (int i = 0; i < NRAND; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         it = refIters(int'(ra), int'(rb));
         runOp("rand", ra, rb, int'(ra) + int'(rb), it);
         checkOutput("rand_iter_bound", (bus.iter_cnt <= WIDTH + 1) ? 1 : 0, 1);
         releaseOutput("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
